ff_bank_arbiter: RTL and testbench

FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

---
 rtl/ff_bank_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit capture register among NREQ requesters,
// with a guard window after every capture. Define FFARB_LOCK_EN for locked re-grants.
module ff_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int GUARD_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] DATA,
  input  logic              NOTIFY,
`ifdef FFARB_LOCK_EN
  input  logic [NREQ-1:0]   LOCK,
`endif
  output logic [NREQ-1:0]   GNT,
  output logic [W-1:0]      Q,
  output logic [W-1:0]      Q_b,
  output logic              VALID,
  output logic              ERR,
  output logic              BUSY,
  output logic [1:0]        fsm_state
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [3:0]      guard_cnt;
  logic [W-1:0]    q;
  logic            valid;
  logic            err;
  logic [NREQ-1:0] gnt;

  logic [NREQ-1:0] win_mask;
  logic [NREQ-1:0] arb_req;
  logic [PW:0]     arb_j;
  logic            arb_hit;
  logic [PW-1:0]   arb_idx;
  logic            load_grant;
  logic [PW-1:0]   grant_idx;
  logic            capture;
  logic            guard_exit;

`ifdef FFARB_LOCK_EN
  logic [2:0]      lock_cnt;
  logic            excl;
  logic            relock;
`endif

  assign win_mask   = NREQ'(1) << win;
  assign guard_exit = (state == S_GUARD) && (guard_cnt == 4'd0);

  // Search from ptr upward with wrap; after a capped lock run the previous
  // winner is masked out as long as somebody else is asking.
  always_comb begin
    arb_req = REQ;
`ifdef FFARB_LOCK_EN
    if (excl && ((REQ & ~win_mask) != '0))
      arb_req = REQ & ~win_mask;
`endif
    arb_hit = 1'b0;
    arb_idx = ptr;
    arb_j   = '0;
    for (int o = 0; o < NREQ; o++) begin
      arb_j = {1'b0, ptr} + (PW+1)'(o);
      if (arb_j >= (PW+1)'(NREQ))
        arb_j = arb_j - (PW+1)'(NREQ);
      if (!arb_hit && arb_req[arb_j[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = arb_j[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_grant = 1'b0;
    grant_idx  = arb_idx;
    capture    = 1'b0;
`ifdef FFARB_LOCK_EN
    relock     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          state_nxt  = S_GRANT;
          load_grant = 1'b1;
        end
      end
      S_GRANT: begin
        state_nxt = S_GUARD;
        capture   = 1'b1;
      end
      S_GUARD: begin
        if (guard_cnt == 4'd0) begin
          state_nxt = S_IDLE;
`ifdef FFARB_LOCK_EN
          if (LOCK[win] && REQ[win] && (lock_cnt < 3'd4)) begin
            state_nxt  = S_GRANT;
            load_grant = 1'b1;
            grant_idx  = win;
            relock     = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win       <= '0;
      guard_cnt <= 4'd0;
      q         <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      gnt       <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= load_grant ? (NREQ'(1) << grant_idx) : '0;
      if (load_grant)
        win <= grant_idx;
      // Capture does not look at REQ: a requester that dropped mid-grant still gets its slot.
      if (capture) begin
        q   <= DATA[int'(win)*W +: W];
        ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
      end
      if (capture)
        guard_cnt <= 4'(GUARD_CYC - 1);
      else if ((state == S_GUARD) && (guard_cnt != 4'd0))
        guard_cnt <= guard_cnt - 4'd1;
      if (NOTIFY) begin
        err   <= 1'b1;
        valid <= 1'b0;
      end else if (capture) begin
        valid <= 1'b1;
      end
    end
  end

`ifdef FFARB_LOCK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_cnt <= 3'd0;
      excl     <= 1'b0;
    end else begin
      if (load_grant) begin
        lock_cnt <= relock ? lock_cnt + 3'd1 : 3'd1;
        if (!relock)
          excl <= 1'b0;
      end
      if (guard_exit && !relock && (lock_cnt == 3'd4))
        excl <= 1'b1;
    end
  end
`endif

  assign GNT       = gnt;
  assign Q         = q;
  assign Q_b       = ~q;
  assign VALID     = valid;
  assign ERR       = err;
  assign BUSY      = (state == S_GRANT) || (state == S_GUARD);
  assign fsm_state = state;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter (NREQ=4, W=8, GUARD_CYC=2).
module tb_ff_bank_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] DATA;
  logic              NOTIFY;
`ifdef FFARB_LOCK_EN
  logic [NREQ-1:0]   LOCK;
`endif
  logic [NREQ-1:0]   GNT;
  logic [W-1:0]      Q;
  logic [W-1:0]      Q_b;
  logic              VALID;
  logic              ERR;
  logic              BUSY;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;
  logic [NREQ-1:0] exp_q[$];

  ff_bank_arbiter #(.NREQ(NREQ), .W(W), .GUARD_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA), .NOTIFY(NOTIFY),
`ifdef FFARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(GNT), .Q(Q), .Q_b(Q_b), .VALID(VALID), .ERR(ERR), .BUSY(BUSY),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    REQ    = '0;
    NOTIFY = 1'b0;
`ifdef FFARB_LOCK_EN
    LOCK   = '0;
`endif
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    DATA = $urandom();
    do_reset();
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", GNT); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
    checks++; if (Q_b !== 8'hFF) begin errors++; $display("FAIL reset_qb: got %h expected ff", Q_b); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", VALID); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
  endtask

  // REQ=0100 applied at edge 1: grant after edge 2, Q at edge 3, idle after edge 5
  task automatic test_single();
    do_reset();
    DATA[2*W +: W] = 8'hA5;
    REQ = 4'b0100;
    tick();
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", GNT); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL single_q_early: got %h expected 00", Q); end
    REQ = 4'b0000;
    tick();
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected a5", Q); end
    checks++; if (Q_b !== 8'h5A) begin errors++; $display("FAIL single_qb: got %h expected 5a", Q_b); end
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", VALID); end
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL single_gnt_guard: got %b expected 0000", GNT); end
    tick();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_guard: got %b expected 1", BUSY); end
    tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", BUSY); end
  endtask

  // all requesters held: strict rotation, one grant every 4 cycles
  task automatic test_rotation();
    int last;
    int ngrant;
    logic [NREQ-1:0] exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) DATA[i*W +: W] = 8'(8'h10 + i);
    exp_q = {};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    last = -1;
    ngrant = 0;
    REQ = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (GNT !== 4'b0000) begin
        ngrant++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rot_extra: got %b expected no further grant", GNT);
        end else begin
          exp = exp_q.pop_front();
          checks++; if (GNT !== exp) begin errors++; $display("FAIL rot_gnt: got %b expected %b", GNT, exp); end
        end
        if (last >= 0) begin
          checks++; if (c - last != 4) begin errors++; $display("FAIL rot_spacing: got %0d expected 4", c - last); end
        end
        last = c;
      end
    end
    REQ = 4'b0000;
    checks++; if (ngrant != 6) begin errors++; $display("FAIL rot_count: got %0d expected 6", ngrant); end
    // last capture was requester 1
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL rot_last_q: got %h expected 11", Q); end
  endtask

  // NOTIFY during GRANT: capture lands but VALID stays low, ERR sticks
  task automatic test_notify();
    do_reset();
    DATA[0*W +: W] = 8'h3C;
    DATA[1*W +: W] = 8'h77;
    REQ = 4'b0001;
    tick();
    checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL ntf_gnt: got %b expected 0001", GNT); end
    REQ = 4'b0000;
    NOTIFY = 1'b1;
    tick();
    NOTIFY = 1'b0;
    checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL ntf_q: got %h expected 3c", Q); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL ntf_valid: got %b expected 0", VALID); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ntf_err: got %b expected 1", ERR); end
    tick();
    tick();
    REQ = 4'b0010;
    tick();
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL ntf_gnt2: got %b expected 0010", GNT); end
    REQ = 4'b0000;
    tick();
    checks++; if (Q !== 8'h77) begin errors++; $display("FAIL ntf_q2: got %h expected 77", Q); end
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL ntf_valid2: got %b expected 1", VALID); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ntf_err_sticky: got %b expected 1", ERR); end
    tick();
    tick();
  endtask

  // RST in the GRANT cycle aborts the capture
  task automatic test_reset_mid_grant();
    do_reset();
    DATA[1*W +: W] = 8'h99;
    REQ = 4'b0010;
    tick();
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL rmg_gnt: got %b expected 0010", GNT); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL rmg_q: got %h expected 00", Q); end
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL rmg_gnt0: got %b expected 0000", GNT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rmg_busy: got %b expected 0", BUSY); end
    tick();
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL rmg_regnt: got %b expected 0010", GNT); end
    REQ = 4'b0000;
    tick();
    checks++; if (Q !== 8'h99) begin errors++; $display("FAIL rmg_q2: got %h expected 99", Q); end
    tick();
    tick();
  endtask

  // request dropped mid-GRANT: still captured, no repeat grant, then idle holds
  task automatic test_drop();
    int extra;
    do_reset();
    DATA[3*W +: W] = 8'hE1;
    REQ = 4'b1000;
    tick();
    checks++; if (GNT !== 4'b1000) begin errors++; $display("FAIL drop_gnt: got %b expected 1000", GNT); end
    REQ = 4'b0000;
    tick();
    checks++; if (Q !== 8'hE1) begin errors++; $display("FAIL drop_q: got %h expected e1", Q); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (GNT !== 4'b0000) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL drop_regrant: got %0d grants expected 0", extra); end
    checks++; if (Q !== 8'hE1 || VALID !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got q=%h valid=%b busy=%b expected q=e1 valid=1 busy=0", Q, VALID, BUSY);
    end
  endtask

  // REQ raised during GUARD is not seen until IDLE
  task automatic test_back_to_back();
    do_reset();
    DATA[0*W +: W] = 8'h01;
    DATA[2*W +: W] = 8'h22;
    REQ = 4'b0001;
    tick();
    REQ = 4'b0000;
    tick();
    REQ = 4'b0100;
    tick();
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL b2b_guard1: got %b expected 0000", GNT); end
    tick();
    checks++; if (GNT !== 4'b0000 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL b2b_guard2: got gnt=%b state=%0d expected gnt=0000 state=0", GNT, fsm_state);
    end
    tick();
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL b2b_gnt: got %b expected 0100", GNT); end
    REQ = 4'b0000;
    tick();
    checks++; if (Q !== 8'h22) begin errors++; $display("FAIL b2b_q: got %h expected 22", Q); end
    tick();
    tick();
  endtask

`ifdef FFARB_LOCK_EN
  task automatic test_lock();
    logic [NREQ-1:0] exp;
    int seen;
    do_reset();
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    LOCK = 4'b0001;
    REQ  = 4'b0011;
    seen = 0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      tick();
      if (GNT !== 4'b0000) begin
        exp = exp_q.pop_front();
        seen++;
        checks++; if (GNT !== exp) begin errors++; $display("FAIL lock_gnt%0d: got %b expected %b", seen, GNT, exp); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lock_timeout: got %0d grants expected 5", seen); end
    REQ  = 4'b0000;
    LOCK = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
  endtask
`endif

  initial begin
    RST    = 1'b1;
    REQ    = '0;
    DATA   = '0;
    NOTIFY = 1'b0;
`ifdef FFARB_LOCK_EN
    LOCK   = '0;
`endif
    test_reset();
    test_single();
    test_rotation();
    test_notify();
    test_reset_mid_grant();
    test_drop();
    test_back_to_back();
`ifdef FFARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
